// File: rtl/ps2_frame_rx.sv
// PS/2 keyboard receive stage: sync, glitch filter, deframe, F0/E0 prefix strip.
// Define PS2_PARITY_CHECK_EN to drop frames that fail odd parity.
module ps2_frame_rx #(
    parameter int FILTER_LEN  = 20,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       kclk,
    input  logic       kdata,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       is_break,
    output logic       is_extended,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]    r_kclk_s;
    logic [1:0]    r_kdata_s;
    logic          r_kclk_f;
    logic          r_kdata_f;
    logic          r_kclk_prev;
    logic [FW-1:0] r_kclk_cnt;
    logic [FW-1:0] r_kdata_cnt;
    state_t        r_state;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_brk;
    logic          r_ext;
    logic [TW-1:0] r_to_cnt;
    logic          w_strobe;
    logic          w_par_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_kclk_s  <= 2'b11;
            r_kdata_s <= 2'b11;
        end else begin
            r_kclk_s  <= {r_kclk_s[0], kclk};
            r_kdata_s <= {r_kdata_s[0], kdata};
        end
    end

    // Filtered level follows only after FILTER_LEN consecutive differing cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            r_kclk_f    <= 1'b1;
            r_kclk_cnt  <= '0;
            r_kclk_prev <= 1'b1;
        end else begin
            r_kclk_prev <= r_kclk_f;
            if (r_kclk_s[1] == r_kclk_f) begin
                r_kclk_cnt <= '0;
            end else if (r_kclk_cnt == FW'(FILTER_LEN - 1)) begin
                r_kclk_f   <= r_kclk_s[1];
                r_kclk_cnt <= '0;
            end else begin
                r_kclk_cnt <= r_kclk_cnt + FW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_kdata_f   <= 1'b1;
            r_kdata_cnt <= '0;
        end else begin
            if (r_kdata_s[1] == r_kdata_f) begin
                r_kdata_cnt <= '0;
            end else if (r_kdata_cnt == FW'(FILTER_LEN - 1)) begin
                r_kdata_f   <= r_kdata_s[1];
                r_kdata_cnt <= '0;
            end else begin
                r_kdata_cnt <= r_kdata_cnt + FW'(1);
            end
        end
    end

    assign w_strobe = r_kclk_prev & ~r_kclk_f;

`ifdef PS2_PARITY_CHECK_EN
    logic r_par;
    assign w_par_ok = ^{r_shift, r_par};
`else
    assign w_par_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_brk       <= 1'b0;
            r_ext       <= 1'b0;
            r_to_cnt    <= '0;
            code        <= 8'h00;
            code_valid  <= 1'b0;
            is_break    <= 1'b0;
            is_extended <= 1'b0;
            frame_err   <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            r_par       <= 1'b0;
`endif
        end else begin
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (w_strobe) begin
                // A strobe always beats a coincident timeout expiry
                r_to_cnt <= '0;
                case (r_state)
                    IDLE: begin
                        if (!r_kdata_f) begin
                            r_state   <= DATA;
                            r_bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        r_shift   <= {r_kdata_f, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= PARITY;
                        end
                    end
                    PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                        r_par   <= r_kdata_f;
`endif
                        r_state <= STOP;
                    end
                    STOP: begin
                        r_state <= IDLE;
                        if (!r_kdata_f || !w_par_ok) begin
                            frame_err <= 1'b1;
                        end else if (r_shift == 8'hF0) begin
                            r_brk <= 1'b1;
                        end else if (r_shift == 8'hE0) begin
                            r_ext <= 1'b1;
                        end else begin
                            code        <= r_shift;
                            is_break    <= r_brk;
                            is_extended <= r_ext;
                            code_valid  <= 1'b1;
                            r_brk       <= 1'b0;
                            r_ext       <= 1'b0;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end else if (r_state != IDLE) begin
                if (r_to_cnt == TW'(TIMEOUT_CYC - 1)) begin
                    frame_err <= 1'b1;
                    r_state   <= IDLE;
                    r_brk     <= 1'b0;
                    r_ext     <= 1'b0;
                    r_to_cnt  <= '0;
                end else begin
                    r_to_cnt <= r_to_cnt + TW'(1);
                end
            end
        end
    end

endmodule

// File: doc/ps2_frame_rx.md
Name: ps2_frame_rx

Overview:
- Upstream PS/2 receive stage for the tank-game keyboard path; sits between the board PS/2 pins and the key-state decoder.
- Synchronises and glitch-filters kclk/kdata, deframes 11-bit PS/2 frames and checks their framing.
- Strips the F0 (break) and E0 (extended) prefixes and presents each completed scan code as a one-cycle strobe with break/extended flags.
- Downstream tracks per-key press/release from code/is_break alone; it needs no bit counting of its own.

Parameters:
- FILTER_LEN, 20: consecutive system-clock cycles a synchronised input must hold a new level before the filtered level follows it.
- TIMEOUT_CYC, 50000: cycles without a filtered kclk falling edge, while mid-frame, before the frame is aborted.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- kclk  in  1  raw PS/2 clock pin, asynchronous.
- kdata  in  1  raw PS/2 data pin, asynchronous.
- code  out  8  last accepted scan code (non-prefix byte).
- code_valid  out  1  one-cycle strobe; code, is_break and is_extended are valid in this cycle.
- is_break  out  1  code was preceded by F0.
- is_extended  out  1  code was preceded by E0.
- frame_err  out  1  one-cycle strobe on any dropped frame.

Behaviour:
- Reset values (rst high at a clk edge): code=8'h00; code_valid, is_break, is_extended, frame_err = 0; FSM=IDLE; bit count=0; prefix flags cleared; filtered kclk/kdata = 1; filter counters = 0; timeout counter = 0.
- Input path: 2-FF synchroniser per pin, then the glitch filter.
- Glitch filter:
  - The filtered level updates only after the synchronised value differs from it for FILTER_LEN consecutive cycles.
  - Any interruption restarts the count.
- Sample strobe: one cycle, on a filtered kclk 1->0 transition. kdata is sampled in that same cycle.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE, strobe with kdata=0 (start bit): go to DATA, bit count=0.
  - IDLE, strobe with kdata=1: ignored, stay IDLE, no error.
  - DATA: shift in LSB first; after the 8th bit go to PARITY.
  - PARITY: store the parity bit; go to STOP.
  - STOP, kdata=1: frame good, go to IDLE and process the byte.
  - STOP, kdata=0: frame_err pulse, byte dropped, go to IDLE.
- Byte processing (cycle after the stop-bit strobe):
  - 8'hF0: set the break flag. No code_valid.
  - 8'hE0: set the extended flag. No code_valid.
  - Any other byte: code <= byte; is_break/is_extended <= flags; code_valid=1 for exactly one cycle; both flags then clear.
  - code holds its value between strobes.
- Latency: code_valid is asserted exactly 1 clk after the strobe that samples the stop bit.
- Timeout:
  - Runs in any non-IDLE state; reloads on every strobe.
  - Expiry at TIMEOUT_CYC: frame_err pulse, FSM to IDLE, partial byte discarded, break/extended flags cleared.
  - Does not run in IDLE.
- Simultaneous events: timeout expiry and a strobe in the same cycle -> the strobe wins, the timeout counter reloads.
- frame_err and code_valid are never high in the same cycle.
- rst mid-frame: everything returns to reset values next cycle; the partial frame is lost with no frame_err pulse.
- Unknown or unsupported bytes (AA, FA, E1 sequences, ...) are passed through as ordinary codes.

Optional Feature:
- Macro: PS2_PARITY_CHECK_EN.
- Defined: odd parity is checked over the 8 data bits plus the parity bit. On mismatch, at STOP: frame_err pulse, byte dropped, prefix flags unchanged.
- Undefined: the parity bit is sampled and ignored; only start, stop and timeout errors exist.

Test Plan:
- Clean frame 0x1D (W), parity=1, stop=1, FILTER_LEN=20 -> one code_valid with code=8'h1D, is_break=0, is_extended=0, exactly 1 clk after the stop strobe.
- Sequence F0 then 1D -> no strobe for F0; a single strobe with code=8'h1D, is_break=1. A following 1D -> is_break=0.
- Sequence E0, F0, 75 -> single strobe with code=8'h75, is_break=1, is_extended=1.
- 10-cycle low glitch on kclk while idle, plus 15-cycle glitches between real edges -> no strobes, no frame_err, FSM stays IDLE.
- 5 bits of frame 0x29 then silence -> frame_err pulse at TIMEOUT_CYC=50000 cycles after the last edge. A subsequent full 0x5A frame then decodes correctly with both flags 0.
- Error cases, both with PS2_PARITY_CHECK_EN defined:
  - 0x23 with wrong parity -> frame_err, no code_valid.
  - 0x23 with correct parity and stop=0 -> frame_err.
  - Build without the macro, wrong parity -> code_valid with code=8'h23.
